load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 56 +++++
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: upstream op channel, memory request
// channel and downstream completion channel.
//
// Handshakes:
//   in_valid/in_ready : an op transfers on a rising edge where both are 1.
//                       in_valid may be raised at any time. Once raised, the
//                       in_* fields must stay stable until the transfer edge.
//   mem_req/mem_gnt   : a request transfers on a rising edge where both are 1.
//                       mem_req and all mem_* fields hold steady until then.
//   mem_rvalid        : read data for the last granted load. It is only
//                       sampled while a load is waiting for its data.
//   out_valid         : one-cycle completion pulse with no backpressure.
interface load_store_unit_if #(parameter int XLEN = 32) ();
  logic            in_valid;
  logic            in_ready;
  logic            in_load;
  logic            in_store;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_wdata;
  logic [4:0]      in_rd;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            out_valid;
  logic            out_we;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_exc;
  logic [XLEN-1:0] out_exc_addr;

  // Seen from the load/store unit
  modport slave (
    input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output out_valid, out_we, out_rd, out_data, out_exc, out_exc_addr
  );

  // Seen from the surrounding pipeline / memory
  modport master (
    output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  out_valid, out_we, out_rd, out_data, out_exc, out_exc_addr
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit. It takes one op at a time from execute and checks
// alignment. For an aligned access it issues a single word-aligned memory
// request, then lane-selects and extends load data. A completion pulse carries
// the writeback or a misaligned-access exception.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state;

  // Op fields captured on accept
  logic            r_load;
  logic            r_store;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [4:0]      r_rd;

  // Decode of the incoming op, used only on the accept cycle
  logic            dec_ld;
  logic            dec_st;
  logic            dec_byte;
  logic            dec_half;
  logic            dec_mis;

  // Decode of the captured op, drives the memory side and load formatting
  logic            r_byte;
  logic            r_half;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_res;

  // Classify the incoming op. Load wins when both class bits are set.
  // Width codes without a legal meaning fall back to a word access.
  always_comb begin
    dec_ld   = bus.in_load;
    dec_st   = bus.in_store && !bus.in_load;
    dec_byte = (bus.in_funct3[1:0] == 2'b00) && !(dec_st && bus.in_funct3[2]);
    dec_half = (bus.in_funct3[1:0] == 2'b01) && !(dec_st && bus.in_funct3[2]);
    dec_mis  = (dec_ld || dec_st) &&
               ((dec_half && bus.in_addr[0]) ||
                (!dec_byte && !dec_half && (bus.in_addr[1:0] != 2'b00)));
  end

  // Width of the captured op, using the same fallback rules as above
  always_comb begin
    r_byte = (r_funct3[1:0] == 2'b00) && !(r_store && r_funct3[2]);
    r_half = (r_funct3[1:0] == 2'b01) && !(r_store && r_funct3[2]);
  end

  // Pick the addressed lane from read data and sign/zero-extend it.
  // funct3[2] set means unsigned (LBU/LHU).
  always_comb begin
    ld_byte = 8'h00;
    case (r_addr[1:0])
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    if (r_byte) begin
      ld_res = {{(XLEN-8){!r_funct3[2] && ld_byte[7]}}, ld_byte};
    end else if (r_half) begin
      ld_res = {{(XLEN-16){!r_funct3[2] && ld_half[15]}}, ld_half};
    end else begin
      ld_res = bus.mem_rdata;
    end
  end

  // Memory request fields come straight from the captured op. They only
  // change on accept, so they stay stable for the whole request.
  always_comb begin
    bus.mem_addr = {r_addr[XLEN-1:2], 2'b00};
    bus.mem_we   = r_store;
    if (!r_store) begin
      bus.mem_be    = 4'b1111;
      bus.mem_wdata = r_wdata;
    end else if (r_byte) begin
      bus.mem_be    = 4'b0001 << r_addr[1:0];
      bus.mem_wdata = {4{r_wdata[7:0]}};
    end else if (r_half) begin
      bus.mem_be    = 4'b0011 << r_addr[1:0];
      bus.mem_wdata = {2{r_wdata[15:0]}};
    end else begin
      bus.mem_be    = 4'b1111;
      bus.mem_wdata = r_wdata;
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_rd       = r_rd;
  assign bus.out_exc_addr = r_addr;
  assign dbg_state        = state;

  // Control FSM with registered request/completion outputs.
  // Reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      r_load        <= 1'b0;
      r_store       <= 1'b0;
      r_funct3      <= 3'd0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rd          <= 5'd0;
      bus.mem_req   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_we    <= 1'b0;
      bus.out_exc   <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r_load   <= dec_ld;
            r_store  <= dec_st;
            r_funct3 <= bus.in_funct3;
            r_addr   <= bus.in_addr;
            r_wdata  <= bus.in_wdata;
            r_rd     <= bus.in_rd;
            if (!dec_ld && !dec_st) begin
              bus.out_data  <= bus.in_addr;
              bus.out_we    <= (bus.in_rd != 5'd0);
              bus.out_exc   <= 1'b0;
              bus.out_valid <= 1'b1;
              state         <= RESP;
            end else if (dec_mis) begin
              bus.out_we    <= 1'b0;
              bus.out_exc   <= 1'b1;
              bus.out_valid <= 1'b1;
              state         <= RESP;
            end else begin
              bus.mem_req <= 1'b1;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            if (r_load) begin
              state <= WAIT;
            end else begin
              bus.out_we    <= 1'b0;
              bus.out_exc   <= 1'b0;
              bus.out_valid <= 1'b1;
              state         <= RESP;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            bus.out_data  <= ld_res;
            bus.out_we    <= (r_rd != 5'd0);
            bus.out_exc   <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          bus.out_valid <= 1'b0;
          bus.out_we    <= 1'b0;
          bus.out_exc   <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit. It applies a directed vector table, hand-written
// reset sequences and random ops checked against a behavioural model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(32)) bus ();

  load_store_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic        exc;
    logic        is_mem;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        mwe;
  } exp_t;

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gd;
    int          rvd;
    exp_t        e;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected result from the architectural rules: access size in bytes,
  // alignment as a modulus, lanes as shifts and masks.
  function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic [31:0] rdat);
    exp_t e;
    int nb;
    bit is_ld, is_st;
    longint unsigned mask, v;
    e = '{default: '0};
    is_ld = ld;
    is_st = st && !ld;
    if (!is_ld && !is_st) begin
      e.data = a;
      e.we   = (rd != 0);
      return e;
    end
    e.is_mem = 1'b1;
    if (f3 == 3'd0 || (is_ld && f3 == 3'd4))      nb = 1;
    else if (f3 == 3'd1 || (is_ld && f3 == 3'd5)) nb = 2;
    else                                          nb = 4;
    if ((a % nb) != 0) begin
      e.exc = 1'b1;
      return e;
    end
    e.maddr = a - (a % 4);
    if (is_st) begin
      e.mwe = 1'b1;
      e.be  = 4'(((1 << nb) - 1) << (a % 4));
      if (nb == 1)      e.mwdata = {24'd0, wd[7:0]} * 32'h0101_0101;
      else if (nb == 2) e.mwdata = {16'd0, wd[15:0]} * 32'h0001_0001;
      else              e.mwdata = wd;
    end else begin
      e.be = 4'hF;
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v = ({32'd0, rdat} >> (8 * (a % 4))) & mask;
      if (f3 < 3'd4 && nb < 4 && v[8*nb-1]) v = v | ~mask;
      e.data = v[31:0];
      e.we   = (rd != 0);
    end
    return e;
  endfunction

  function automatic vec_t mkv(input string n, input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                               input logic [31:0] rdat, input int gd, input int rvd,
                               input logic [31:0] edata, input logic ewe, input logic eexc,
                               input logic eism, input logic [31:0] emaddr, input logic [3:0] ebe,
                               input logic [31:0] emw, input logic emwe);
    vec_t v;
    v.name = n; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd;
    v.rdata = rdat; v.gd = gd; v.rvd = rvd;
    v.e.data = edata; v.e.we = ewe; v.e.exc = eexc; v.e.is_mem = eism;
    v.e.maddr = emaddr; v.e.be = ebe; v.e.mwdata = emw; v.e.mwe = emwe;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0;
    bus.in_funct3 = 3'd0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_rd = 5'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Issue one op from an idle sample point, act as memory and check the
  // request, the completion pulse and its latency.
  task automatic run_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdat, input int gd, input int rvd, input exp_t e);
    int cyc, req_cnt, gnt_cyc, lat;
    bit done;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_we;
    logic [31:0] exp_data;
    s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0;
    if (!e.is_mem || e.exc) lat = 1;
    else if (e.mwe)         lat = gd + 2;
    else                    lat = gd + rvd + 3;
    exp_q.push_back(e.data);
    chk({nm, ":ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_load = ld; bus.in_store = st; bus.in_funct3 = f3;
    bus.in_addr = a; bus.in_wdata = wd; bus.in_rd = rd;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_addr = $urandom; bus.in_wdata = $urandom;
    cyc = 1; req_cnt = 0; gnt_cyc = -1; done = 0;
    while (!done && cyc < 60) begin
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      if (bus.out_valid) begin
        done = 1;
        exp_data = exp_q.pop_front();
        chk({nm, ":latency"}, cyc, lat);
        chk({nm, ":req_in_resp"}, bus.mem_req, 0);
        chk({nm, ":out_exc"}, bus.out_exc, e.exc);
        chk({nm, ":out_we"}, bus.out_we, e.we);
        chk({nm, ":out_rd"}, bus.out_rd, rd);
        if (e.exc) chk({nm, ":exc_addr"}, bus.out_exc_addr, a);
        if (!e.exc && !e.mwe) chk({nm, ":out_data"}, bus.out_data, exp_data);
      end else begin
        chk({nm, ":ready_busy"}, bus.in_ready, 0);
        if (bus.mem_req) begin
          if (!e.is_mem || e.exc || gnt_cyc >= 0) chk({nm, ":unexpected_req"}, 1, 0);
          if (req_cnt == 0) begin
            s_addr = bus.mem_addr; s_be = bus.mem_be; s_we = bus.mem_we; s_wdata = bus.mem_wdata;
            chk({nm, ":mem_addr"}, bus.mem_addr, e.maddr);
            chk({nm, ":mem_be"}, bus.mem_be, e.be);
            chk({nm, ":mem_we"}, bus.mem_we, e.mwe);
            if (e.mwe) chk({nm, ":mem_wdata"}, bus.mem_wdata, e.mwdata);
          end else begin
            chk({nm, ":stable_addr"}, bus.mem_addr, s_addr);
            chk({nm, ":stable_be"}, bus.mem_be, s_be);
            chk({nm, ":stable_we"}, bus.mem_we, s_we);
            chk({nm, ":stable_wdata"}, bus.mem_wdata, s_wdata);
          end
          if (req_cnt == gd) begin
            bus.mem_gnt = 1'b1;
            gnt_cyc = cyc;
          end else if ($urandom_range(0, 1) == 1) begin
            bus.mem_rvalid = 1'b1;
          end
          req_cnt++;
        end else if (gnt_cyc >= 0 && cyc == gnt_cyc + 1 + rvd) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = rdat;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    if (!done) begin
      chk({nm, ":timeout"}, 1, 0);
      void'(exp_q.pop_front());
      do_reset();
    end else begin
      @(posedge clk); #1;
      chk({nm, ":pulse_end"}, bus.out_valid, 0);
      chk({nm, ":ready_after"}, bus.in_ready, 1);
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] a, wd, rdat;
    logic [4:0] rd;
    int k;

    vecs.push_back(mkv("nonmem",       0,0,3'd0,32'h0000_1234,32'h0,5, 32'h0,0,0, 32'h0000_1234,1,0,0, 32'h0,4'h0,32'h0,0));
    vecs.push_back(mkv("nonmem_rd0",   0,0,3'd2,32'hDEAD_BEEF,32'h55,0,32'h0,0,0, 32'hDEAD_BEEF,0,0,0, 32'h0,4'h0,32'h0,0));
    vecs.push_back(mkv("lb_neg",       1,0,3'd0,32'h0000_1003,32'h0,7, 32'h80FF_0000,0,0, 32'hFFFF_FF80,1,0,1, 32'h1000,4'hF,32'h0,0));
    vecs.push_back(mkv("lbu",          1,0,3'd4,32'h0000_1003,32'h0,7, 32'h80FF_0000,0,0, 32'h0000_0080,1,0,1, 32'h1000,4'hF,32'h0,0));
    vecs.push_back(mkv("sh_hi",        0,1,3'd1,32'h0000_2002,32'h0000_ABCD,3,32'h0,0,0, 32'h0,0,0,1, 32'h2000,4'b1100,32'hABCD_ABCD,1));
    vecs.push_back(mkv("lw_mis",       1,0,3'd2,32'h0000_3001,32'h0,4, 32'h0,0,0, 32'h0,0,1,1, 32'h0,4'h0,32'h0,0));
    vecs.push_back(mkv("lh_neg",       1,0,3'd1,32'h0000_1002,32'h0,9, 32'h8001_0000,0,0, 32'hFFFF_8001,1,0,1, 32'h1000,4'hF,32'h0,0));
    vecs.push_back(mkv("lhu_slow",     1,0,3'd5,32'h0000_1002,32'h0,9, 32'h8001_0000,1,1, 32'h0000_8001,1,0,1, 32'h1000,4'hF,32'h0,0));
    vecs.push_back(mkv("sb_b1",        0,1,3'd0,32'h0000_4001,32'h1234_5678,2,32'h0,0,0, 32'h0,0,0,1, 32'h4000,4'b0010,32'h7878_7878,1));
    vecs.push_back(mkv("sw_gnt3",      0,1,3'd2,32'h0000_4000,32'hCAFE_F00D,2,32'h0,3,0, 32'h0,0,0,1, 32'h4000,4'hF,32'hCAFE_F00D,1));
    vecs.push_back(mkv("lw_slow",      1,0,3'd2,32'h0000_5004,32'h0,31,32'h1122_3344,2,2, 32'h1122_3344,1,0,1, 32'h5004,4'hF,32'h0,0));
    vecs.push_back(mkv("sh_mis",       0,1,3'd1,32'h0000_2001,32'hFFFF,3,32'h0,0,0, 32'h0,0,1,1, 32'h0,4'h0,32'h0,0));
    vecs.push_back(mkv("ld_f3_011_mis",1,0,3'd3,32'h0000_6002,32'h0,1, 32'h0,0,0, 32'h0,0,1,1, 32'h0,4'h0,32'h0,0));
    vecs.push_back(mkv("st_f3_100_mis",0,1,3'd4,32'h0000_7001,32'h0,1, 32'h0,0,0, 32'h0,0,1,1, 32'h0,4'h0,32'h0,0));
    vecs.push_back(mkv("st_f3_101_w",  0,1,3'd5,32'h0000_7000,32'h0102_0304,1,32'h0,0,0, 32'h0,0,0,1, 32'h7000,4'hF,32'h0102_0304,1));
    vecs.push_back(mkv("ld_st_both",   1,1,3'd0,32'h0000_1001,32'h99,6,32'h0000_7F00,0,0, 32'h0000_007F,1,0,1, 32'h1000,4'hF,32'h0,0));
    vecs.push_back(mkv("lw_rd0",       1,0,3'd2,32'h0000_0100,32'h0,0, 32'h0000_0005,0,1, 32'h0000_0005,0,0,1, 32'h0100,4'hF,32'h0,0));
    vecs.push_back(mkv("lhu_mis",      1,0,3'd5,32'h0000_1001,32'h0,2, 32'h0,0,0, 32'h0,0,1,1, 32'h0,4'h0,32'h0,0));
    vecs.push_back(mkv("ld_f3_110_w",  1,0,3'd6,32'h0000_8000,32'h0,1, 32'h89AB_CDEF,0,0, 32'h89AB_CDEF,1,0,1, 32'h8000,4'hF,32'h0,0));
    vecs.push_back(mkv("sb_b3",        0,1,3'd0,32'h0000_4003,32'h0000_00A5,1,32'h0,0,0, 32'h0,0,0,1, 32'h4000,4'b1000,32'hA5A5_A5A5,1));

    do_reset();
    chk("rst:in_ready", bus.in_ready, 1);
    chk("rst:mem_req", bus.mem_req, 0);
    chk("rst:out_valid", bus.out_valid, 0);
    chk("rst:out_we", bus.out_we, 0);
    chk("rst:out_exc", bus.out_exc, 0);
    chk("rst:out_data", bus.out_data, 0);
    chk("rst:mem_addr", bus.mem_addr, 0);
    chk("rst:out_exc_addr", bus.out_exc_addr, 0);

    // Directed table
    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v.name, v.ld, v.st, v.f3, v.addr, v.wd, v.rd, v.rdata, v.gd, v.rvd, v.e);
    end

    // Reset while waiting for read data abandons the load
    bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_store = 1'b0; bus.in_funct3 = 3'd2;
    bus.in_addr = 32'h0000_9000; bus.in_rd = 5'd8;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rstwait:req", bus.mem_req, 1);
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    chk("rstwait:req_dropped", bus.mem_req, 0);
    chk("rstwait:no_valid", bus.out_valid, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstwait:ready", bus.in_ready, 1);
    chk("rstwait:mem_req", bus.mem_req, 0);
    chk("rstwait:out_valid", bus.out_valid, 0);
    chk("rstwait:out_we", bus.out_we, 0);
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      chk("rstwait:late_rvalid", bus.out_valid, 0);
      chk("rstwait:still_ready", bus.in_ready, 1);
    end
    bus.mem_rvalid = 1'b0;

    // Reset while requesting abandons the store; a later grant is ignored
    bus.in_valid = 1'b1; bus.in_load = 1'b0; bus.in_store = 1'b1; bus.in_funct3 = 3'd2;
    bus.in_addr = 32'h0000_A000; bus.in_wdata = 32'h5555_AAAA; bus.in_rd = 5'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rstreq:req", bus.mem_req, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstreq:mem_req", bus.mem_req, 0);
    chk("rstreq:ready", bus.in_ready, 1);
    for (int i = 0; i < 2; i++) begin
      bus.mem_gnt = 1'b1;
      @(posedge clk); #1;
      chk("rstreq:late_gnt", bus.out_valid, 0);
    end
    bus.mem_gnt = 1'b0;

    // Recovery after the reset sequences
    v = vecs[2];
    run_op("recover_lb", v.ld, v.st, v.f3, v.addr, v.wd, v.rd, v.rdata, v.gd, v.rvd, v.e);

    // Random ops against the model
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 3);
      ld = (k == 1 || k == 3);
      st = (k == 2 || k == 3);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      wd = $urandom;
      rdat = $urandom;
      rd = 5'($urandom_range(0, 31));
      e = model(ld, st, f3, a, wd, rd, rdat);
      run_op("rand", ld, st, f3, a, wd, rd, rdat, $urandom_range(0, 3), $urandom_range(0, 3), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
